// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module      : branch_resolve_unit
// Description : Execute-stage branch/jump resolution with a link-result FIFO.
//               Optional statistics counters enabled by defining BRU_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
  parameter int XLEN     = 32,
  parameter int WB_DEPTH = 2,
  parameter int ID_W     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] offset,
  input  logic [2:0]      fn3,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            use_signed,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  input  logic [ID_W-1:0] tag,
  input  logic            flush,
  output logic            ex_valid,
  output logic            ex_taken,
  output logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_mispredict,
  output logic            wb_done,
  output logic [XLEN-1:0] wb_rd,
  output logic [ID_W-1:0] wb_tag,
  input  logic            wb_accepted
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_mispredict
`endif
);

  localparam int                c_PTR_W   = $clog2(WB_DEPTH);
  localparam int                c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(WB_DEPTH);
  localparam logic [XLEN-1:0]    c_FOUR    = XLEN'(4);
  localparam logic [XLEN-1:0]    c_LSB_CLR = ~(XLEN'(1));

  logic              r_ex_valid, r_ex_taken, r_ex_mis, r_ex_link;
  logic [XLEN-1:0]   r_ex_target, r_ex_pc, r_ex_rd;
  logic [ID_W-1:0]   r_ex_tag;
  logic [XLEN-1:0]   r_fifo_rd  [WB_DEPTH];
  logic [ID_W-1:0]   r_fifo_tag [WB_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic              w_accept, w_eq, w_lt, w_cmp, w_taken, w_mis;
  logic              w_push, w_pop, w_push_ok;
  logic [XLEN:0]     w_sub;
  logic [XLEN-1:0]   w_jump_tgt, w_pc4, w_target;
  logic [c_CNT_W-1:0] w_pending;

  // Sign-extend by one bit so a single subtract covers signed and unsigned order.
  assign w_sub = {use_signed & rs1[XLEN-1], rs1} - {use_signed & rs2[XLEN-1], rs2};
  assign w_eq  = ~|w_sub[XLEN-1:0];
  assign w_lt  = w_sub[XLEN];

  always_comb begin
    w_cmp = 1'b0;
    case (fn3)
      3'b000:  w_cmp = w_eq;
      3'b001:  w_cmp = ~w_eq;
      3'b100:  w_cmp = w_lt;
      3'b101:  w_cmp = ~w_lt;
      3'b110:  w_cmp = w_lt;
      3'b111:  w_cmp = ~w_lt;
      default: w_cmp = 1'b0;
    endcase
  end

  assign w_taken    = (is_branch & w_cmp) | is_jal | is_jalr;
  assign w_jump_tgt = is_jalr ? ((rs1 + offset) & c_LSB_CLR) : (pc + offset);
  assign w_pc4      = pc + c_FOUR;
  assign w_target   = w_taken ? w_jump_tgt : w_pc4;
  assign w_mis      = (w_taken != pred_taken) | (w_taken & (pred_target != w_target));

  // A link op still in ex will claim a FIFO slot next cycle, so it is reserved now.
  assign w_pending   = (r_ex_valid & r_ex_link) ? c_CNT_ONE : '0;
  assign issue_ready = ((r_count + w_pending) < c_DEPTH) & ~flush;
  assign w_accept    = issue_valid & issue_ready;

  assign w_push    = r_ex_valid & r_ex_link & ~flush;
  assign w_pop     = (r_count != '0) & wb_accepted;
  assign w_push_ok = w_push & ((r_count != c_DEPTH) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_taken  <= 1'b0;
      r_ex_mis    <= 1'b0;
      r_ex_link   <= 1'b0;
      r_ex_target <= '0;
      r_ex_pc     <= '0;
      r_ex_rd     <= '0;
      r_ex_tag    <= '0;
    end else begin
      r_ex_valid <= w_accept;
      r_ex_mis   <= w_accept & w_mis;
      if (w_accept) begin
        r_ex_taken  <= w_taken;
        r_ex_link   <= is_jal | is_jalr;
        r_ex_target <= w_target;
        r_ex_pc     <= pc;
        r_ex_rd     <= w_pc4;
        r_ex_tag    <= tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        r_fifo_rd[i]  <= '0;
        r_fifo_tag[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_fifo_rd[r_wr_ptr]  <= r_ex_rd;
        r_fifo_tag[r_wr_ptr] <= r_ex_tag;
        r_wr_ptr             <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ex_valid      = r_ex_valid & ~flush;
  assign ex_taken      = r_ex_taken;
  assign ex_target     = r_ex_target;
  assign ex_pc         = r_ex_pc;
  assign ex_mispredict = r_ex_mis & ~flush;
  assign wb_done       = (r_count != '0);
  assign wb_rd         = r_fifo_rd[r_rd_ptr];
  assign wb_tag        = r_fifo_tag[r_rd_ptr];

`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else begin
      if (ex_valid && (stat_resolved != 32'hFFFF_FFFF)) begin
        stat_resolved <= stat_resolved + 32'd1;
      end
      if (ex_mispredict && (stat_mispredict != 32'hFFFF_FFFF)) begin
        stat_mispredict <= stat_mispredict + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Vector table plus scoreboarded sequences for branch_resolve_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0, issue_ready;
  logic [31:0] rs1 = '0, rs2 = '0, pc = '0, offset = '0, pred_target = '0;
  logic [2:0]  fn3 = '0, tag = '0;
  logic        is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
  logic        use_signed = 1'b0, pred_taken = 1'b0, flush = 1'b0;
  logic        ex_valid, ex_taken, ex_mispredict, wb_done;
  logic [31:0] ex_target, ex_pc, wb_rd;
  logic [2:0]  wb_tag;
  logic        wb_accepted = 1'b0;
`ifdef BRU_STATS_EN
  logic [31:0] stat_resolved, stat_mispredict;
`endif

  branch_resolve_unit #(.XLEN(32), .WB_DEPTH(2), .ID_W(3)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .pc(pc), .offset(offset), .fn3(fn3),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .use_signed(use_signed), .pred_taken(pred_taken), .pred_target(pred_target),
    .tag(tag), .flush(flush), .ex_valid(ex_valid), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pc(ex_pc), .ex_mispredict(ex_mispredict),
    .wb_done(wb_done), .wb_rd(wb_rd), .wb_tag(wb_tag), .wb_accepted(wb_accepted)
`ifdef BRU_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1, rs2, pc, off;
    logic [2:0]  fn3;
    logic        br, jal, jalr, sgn, pt;
    logic [31:0] ptgt;
    logic [2:0]  tag;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic        e_mis;
  } vec_t;

  typedef struct { logic taken; logic mis; logic [31:0] tgt, pc; } ex_exp_t;
  typedef struct { logic [31:0] rd; logic [2:0] tag; } wb_exp_t;

  ex_exp_t ex_q[$];
  wb_exp_t wb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_resolved = 0;
  int n_mis = 0;
  vec_t vecs[17];

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [31:0] p, logic [31:0] o,
                              logic [2:0] f, logic br, logic jal, logic jalr, logic sgn,
                              logic pt, logic [31:0] ptgt, logic [2:0] t,
                              logic et, logic [31:0] etgt, logic em);
    vec_t v;
    v.rs1 = a; v.rs2 = b; v.pc = p; v.off = o; v.fn3 = f;
    v.br = br; v.jal = jal; v.jalr = jalr; v.sgn = sgn; v.pt = pt;
    v.ptgt = ptgt; v.tag = t; v.e_taken = et; v.e_tgt = etgt; v.e_mis = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ex result and every FIFO pop is matched in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (ex_valid) begin
        n_resolved++;
        if (ex_mispredict) n_mis++;
        if (ex_q.size() == 0) begin
          check("ex_unexpected", {95'd0, ex_valid}, 96'd0);
        end else begin
          ex_exp_t e;
          e = ex_q.pop_front();
          check("ex_result", {30'd0, ex_taken, ex_mispredict, ex_target, ex_pc},
                {30'd0, e.taken, e.mis, e.tgt, e.pc});
        end
      end else if (ex_q.size() != 0) begin
        void'(ex_q.pop_front());
        check("ex_missing", {95'd0, ex_valid}, 96'd1);
      end
      if (wb_done && wb_accepted) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", {95'd0, wb_done}, 96'd0);
        end else begin
          wb_exp_t w;
          w = wb_q.pop_front();
          check("wb_head", {61'd0, wb_tag, wb_rd}, {61'd0, w.tag, w.rd});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_inputs(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; pc = v.pc; offset = v.off; fn3 = v.fn3;
    is_branch = v.br; is_jal = v.jal; is_jalr = v.jalr; use_signed = v.sgn;
    pred_taken = v.pt; pred_target = v.ptgt; tag = v.tag;
  endtask

  task automatic idle();
    issue_valid = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic drive(input vec_t v);
    int n;
    ex_exp_t e;
    wb_exp_t w;
    set_inputs(v);
    issue_valid = 1'b1;
    flush = 1'b0;
    #1;
    n = 0;
    while (!issue_ready && n < 20) begin
      cyc();
      n++;
    end
    if (!issue_ready) begin
      check("issue_timeout", {95'd0, issue_ready}, 96'd1);
      idle();
    end else begin
      cyc();
      e.taken = v.e_taken; e.mis = v.e_mis; e.tgt = v.e_tgt; e.pc = v.pc;
      ex_q.push_back(e);
      if (v.jal || v.jalr) begin
        w.rd = v.pc + 32'd4; w.tag = v.tag;
        wb_q.push_back(w);
      end
    end
  endtask

  function automatic vec_t jal_op(logic [31:0] p, logic [2:0] t);
    return mk(0, 0, p, 32'h40, 3'd0, 0, 1, 0, 0, 1, p + 32'h40, t, 1, p + 32'h40, 0);
  endfunction

  initial begin
    vecs[0]  = mk(5, 5, 32'h100, 32'h20, 3'b000, 1,0,0,0, 0, 0, 0, 1, 32'h120, 1);
    vecs[1]  = mk(5, 6, 32'h100, 32'h20, 3'b000, 1,0,0,0, 0, 0, 0, 0, 32'h104, 0);
    vecs[2]  = mk(5, 6, 32'h200, 32'hFFFF_FFF8, 3'b001, 1,0,0,0, 1, 32'h1F8, 0, 1, 32'h1F8, 0);
    vecs[3]  = mk(32'hFFFF_FFFF, 1, 32'h300, 32'h40, 3'b100, 1,0,0,1, 1, 32'h340, 0, 1, 32'h340, 0);
    vecs[4]  = mk(32'hFFFF_FFFF, 1, 32'h300, 32'h40, 3'b110, 1,0,0,0, 1, 32'h340, 0, 0, 32'h304, 1);
    vecs[5]  = mk(1, 32'hFFFF_FFFF, 32'h500, 32'h10, 3'b101, 1,0,0,1, 0, 0, 0, 1, 32'h510, 1);
    vecs[6]  = mk(1, 32'hFFFF_FFFF, 32'h500, 32'h10, 3'b111, 1,0,0,0, 0, 0, 0, 0, 32'h504, 0);
    vecs[7]  = mk(9, 9, 32'h600, 32'h8, 3'b010, 1,0,0,0, 0, 0, 0, 0, 32'h604, 0);
    vecs[8]  = mk(32'h8000_0000, 32'h7FFF_FFFF, 32'h700, 32'hC, 3'b100, 1,0,0,1, 1, 32'h70C, 0, 1, 32'h70C, 0);
    vecs[9]  = mk(32'h8000_0000, 32'h7FFF_FFFF, 32'h700, 32'hC, 3'b110, 1,0,0,0, 0, 0, 0, 0, 32'h704, 0);
    vecs[10] = mk(32'h203, 0, 32'h400, 32'h10, 3'b000, 0,0,1,0, 1, 32'h212, 5, 1, 32'h212, 0);
    vecs[11] = mk(0, 0, 32'h800, 32'h100, 3'b000, 0,1,0,0, 1, 32'h904, 2, 1, 32'h900, 1);
    vecs[12] = mk(7, 7, 32'hFFFF_FFFC, 32'h40, 3'b001, 1,0,0,0, 0, 0, 0, 0, 32'h0, 0);
    vecs[13] = mk(0, 0, 32'hFFFF_FFF0, 32'h20, 3'b000, 0,1,0,0, 0, 0, 6, 1, 32'h10, 1);
    vecs[14] = mk(32'hFFFF_FFFF, 0, 32'h40, 32'h2, 3'b000, 0,0,1,0, 1, 32'h0, 1, 1, 32'h0, 0);
    vecs[15] = mk(1, 2, 32'h1000, 32'h10, 3'b001, 1,0,0,0, 1, 32'h1014, 0, 1, 32'h1010, 1);
    vecs[16] = mk(1, 2, 32'h1000, 32'h10, 3'b000, 1,0,0,0, 0, 32'hDEAD, 0, 0, 32'h1004, 0);

    // Reset state
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    check("reset_ctrl", {91'd0, issue_ready, ex_valid, ex_taken, ex_mispredict, wb_done},
          {91'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset_data", {ex_target, ex_pc, wb_rd}, 96'd0);
    check("reset_tag", {93'd0, wb_tag}, 96'd0);

    // Vector table, back to back, writeback always accepting
    wb_accepted = 1'b1;
    for (int i = 0; i < 17; i++) drive(vecs[i]);
    idle();
    repeat (4) cyc();

    // Link FIFO backpressure and ordering
    wb_accepted = 1'b0;
    drive(jal_op(32'h2000, 3'd1));
    check("ready_after_1", {95'd0, issue_ready}, 96'd1);
    drive(jal_op(32'h2100, 3'd2));
    idle();
    check("ready_after_2", {95'd0, issue_ready}, 96'd0);
    repeat (3) cyc();
    check("full_stall", {59'd0, issue_ready, wb_done, wb_tag, wb_rd},
          {59'd0, 1'b0, 1'b1, 3'd1, 32'h2004});
    wb_accepted = 1'b1;
    cyc();
    wb_accepted = 1'b0;
    check("ready_after_pop", {95'd0, issue_ready}, 96'd1);
    drive(jal_op(32'h2200, 3'd3));
    idle();
    wb_accepted = 1'b1;
    repeat (5) cyc();

    // Flush in the ex cycle of a JAL, plus a same-cycle issue that must be dropped
    wb_accepted = 1'b0;
    drive(jal_op(32'h3000, 3'd4));
    idle();
    repeat (2) cyc();
    set_inputs(jal_op(32'h3100, 3'd6));
    issue_valid = 1'b1;
    #1;
    check("flush_pre_ready", {95'd0, issue_ready}, 96'd1);
    cyc();
    set_inputs(jal_op(32'h3200, 3'd7));
    flush = 1'b1;
    #1;
    check("flush_kill", {94'd0, ex_valid, issue_ready}, 96'd0);
    cyc();
    flush = 1'b0;
    idle();
    check("flush_no_issue", {95'd0, ex_valid}, 96'd0);
    check("flush_fifo_head", {60'd0, wb_done, wb_tag, wb_rd}, {60'd0, 1'b1, 3'd4, 32'h3004});
    wb_accepted = 1'b1;
    repeat (4) cyc();
    check("flush_drained", {95'd0, wb_done}, 96'd0);
    check("wb_q_empty", 96'(wb_q.size()), 96'd0);

`ifdef BRU_STATS_EN
    check("stat_resolved", {64'd0, stat_resolved}, 96'(n_resolved));
    check("stat_mispredict", {64'd0, stat_mispredict}, 96'(n_mis));
`endif

    // Reset mid-operation discards queued link results
    wb_accepted = 1'b0;
    drive(jal_op(32'h4000, 3'd5));
    idle();
    repeat (2) cyc();
    check("pre_reset_fifo", {95'd0, wb_done}, 96'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wb_q.delete();
    ex_q.delete();
    check("mid_reset", {93'd0, issue_ready, ex_valid, wb_done}, {93'd0, 1'b1, 1'b0, 1'b0});
`ifdef BRU_STATS_EN
    check("stat_reset", {32'd0, stat_resolved, stat_mispredict}, 96'd0);
`endif
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
